// File: rtl/cpu_dma_rx_queue.sv
// Host-to-datapath receive queue. Packs 32-bit little-endian DMA words into 64-bit big-endian
// words and forwards each whole packet behind an IOQ module header.
module cpu_dma_rx_queue #(
    parameter int unsigned DATA_WIDTH                 = 64,
    parameter int unsigned CTRL_WIDTH                 = DATA_WIDTH / 8,
    parameter int unsigned DMA_DATA_WIDTH             = 32,
    parameter int unsigned DMA_CTRL_WIDTH             = DMA_DATA_WIDTH / 8,
    parameter logic [CTRL_WIDTH-1:0] STAGE_NUMBER     = 'hff,
    parameter logic [15:0] PORT_NUMBER                = 16'd0,
    parameter int unsigned DATA_FIFO_DEPTH_BITS       = 9,
    parameter int unsigned LEN_FIFO_DEPTH_BITS        = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      cpu_q_dma_can_wr_pkt,
    input  logic                      cpu_q_dma_wr,
    input  logic [DMA_DATA_WIDTH-1:0] cpu_q_dma_wr_data,
    input  logic [DMA_CTRL_WIDTH-1:0] cpu_q_dma_wr_ctrl,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic [CTRL_WIDTH-1:0]     out_ctrl,
    output logic                      out_wr,
    input  logic                      out_rdy,
    input  logic                      rx_queue_en,
    output logic                      rx_pkt_stored,
    output logic                      rx_pkt_removed,
    output logic                      rx_q_overrun,
    output logic [11:0]               rx_pkt_byte_cnt,
    output logic [9:0]                rx_pkt_word_cnt
);
    localparam int unsigned DB          = DATA_FIFO_DEPTH_BITS;
    localparam int unsigned LB          = LEN_FIFO_DEPTH_BITS;
    localparam int unsigned FW          = CTRL_WIDTH + DATA_WIDTH;
    localparam int unsigned DDepth      = 1 << DB;
    localparam int unsigned LDepth      = 1 << LB;
    localparam int unsigned MaxPktWords = 256;

    typedef enum logic {StHdr, StBody} out_state_e;

    logic                      half_q;
    logic [DMA_DATA_WIDTH-1:0] lo_data_q;
    logic [11:0]               byte_cnt_q;
    logic [DMA_DATA_WIDTH-1:0] rev_data;
    logic [3:0]                rev_ctrl;
    logic                      is_last;
    logic [11:0]               last_add;
    logic [11:0]               pkt_bytes;
    logic [12:0]               pkt_wsum;
    logic                      push;
    logic [FW-1:0]             push_word;

    logic [FW-1:0] data_mem [DDepth];
    logic [DB:0]   dwr_q, drd_q, dcount;
    logic          dfull, dempty, dwr, dpop, room_ok;
    logic [11:0]   len_mem [LDepth];
    logic [LB:0]   lwr_q, lrd_q;
    logic          lfull, lempty, lpop;
    logic [11:0]   len_head;
    logic [12:0]   hdr_wsum;
    logic [FW-1:0] dhead;

    out_state_e              state_q, state_d;
    logic                    out_wr_q, out_wr_d, removed_q, removed_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [CTRL_WIDTH-1:0]   out_ctrl_q, out_ctrl_d;
    logic                    stored_q, overrun_q, can_wr_q;
    logic [11:0]             stored_bytes_q;
    logic [9:0]              stored_words_q;

    // Packer: byte 0 of each DMA word becomes the most significant byte of its half.
    always_comb begin
        rev_data = {cpu_q_dma_wr_data[7:0], cpu_q_dma_wr_data[15:8],
                    cpu_q_dma_wr_data[23:16], cpu_q_dma_wr_data[31:24]};
        rev_ctrl = {cpu_q_dma_wr_ctrl[0], cpu_q_dma_wr_ctrl[1],
                    cpu_q_dma_wr_ctrl[2], cpu_q_dma_wr_ctrl[3]};
        is_last  = |cpu_q_dma_wr_ctrl;
        if (cpu_q_dma_wr_ctrl[3])      last_add = 12'd4;
        else if (cpu_q_dma_wr_ctrl[2]) last_add = 12'd3;
        else if (cpu_q_dma_wr_ctrl[1]) last_add = 12'd2;
        else                           last_add = 12'd1;
        pkt_bytes = byte_cnt_q + (is_last ? last_add : 12'd4);
        pkt_wsum  = {1'b0, pkt_bytes} + 13'd7;
        push      = 1'b0;
        push_word = '0;
        if (cpu_q_dma_wr) begin
            if (half_q) begin
                push      = 1'b1;
                push_word = {4'b0, rev_ctrl, lo_data_q, rev_data};
            end else if (is_last) begin
                push      = 1'b1;
                push_word = {rev_ctrl, 4'b0, rev_data, 32'b0};
            end
        end
    end

    always_comb begin
        dcount   = dwr_q - drd_q;
        dfull    = dcount[DB];
        dempty   = (dwr_q == drd_q);
        dwr      = push && !dfull;
        room_ok  = (32'(dcount) + MaxPktWords) <= DDepth;
        lfull    = (lwr_q[LB] != lrd_q[LB]) && (lwr_q[LB-1:0] == lrd_q[LB-1:0]);
        lempty   = (lwr_q == lrd_q);
        len_head = len_mem[lrd_q[LB-1:0]];
        hdr_wsum = {1'b0, len_head} + 13'd7;
        dhead    = data_mem[drd_q[DB-1:0]];
    end

    always_comb begin
        state_d    = state_q;
        out_wr_d   = 1'b0;
        out_data_d = out_data_q;
        out_ctrl_d = out_ctrl_q;
        removed_d  = 1'b0;
        dpop       = 1'b0;
        lpop       = 1'b0;
        unique case (state_q)
            StHdr: begin
                if (!lempty && rx_queue_en && out_rdy) begin
                    out_wr_d   = 1'b1;
                    out_ctrl_d = STAGE_NUMBER;
                    out_data_d = {16'h0, 6'h0, hdr_wsum[12:3], PORT_NUMBER, 4'h0, len_head};
                    lpop       = 1'b1;
                    state_d    = StBody;
                end
            end
            StBody: begin
                // Enable only gates headers; a started packet always drains.
                if (out_rdy && !dempty) begin
                    out_wr_d   = 1'b1;
                    out_ctrl_d = dhead[FW-1:DATA_WIDTH];
                    out_data_d = dhead[DATA_WIDTH-1:0];
                    dpop       = 1'b1;
                    if (|dhead[FW-1:DATA_WIDTH]) begin
                        removed_d = 1'b1;
                        state_d   = StHdr;
                    end
                end
            end
            default: state_d = StHdr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (dwr) data_mem[dwr_q[DB-1:0]] <= push_word;
        if (stored_q && !lfull) len_mem[lwr_q[LB-1:0]] <= stored_bytes_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            half_q         <= 1'b0;
            lo_data_q      <= '0;
            byte_cnt_q     <= '0;
            dwr_q          <= '0;
            drd_q          <= '0;
            lwr_q          <= '0;
            lrd_q          <= '0;
            state_q        <= StHdr;
            out_wr_q       <= 1'b0;
            out_data_q     <= '0;
            out_ctrl_q     <= '0;
            removed_q      <= 1'b0;
            stored_q       <= 1'b0;
            overrun_q      <= 1'b0;
            can_wr_q       <= 1'b0;
            stored_bytes_q <= '0;
            stored_words_q <= '0;
        end else begin
            if (cpu_q_dma_wr) begin
                if (!half_q && !is_last) begin
                    half_q    <= 1'b1;
                    lo_data_q <= rev_data;
                end else begin
                    half_q <= 1'b0;
                end
                byte_cnt_q <= is_last ? 12'd0 : pkt_bytes;
            end
            stored_q <= cpu_q_dma_wr && is_last;
            if (cpu_q_dma_wr && is_last) begin
                stored_bytes_q <= pkt_bytes;
                stored_words_q <= pkt_wsum[12:3];
            end
            overrun_q <= cpu_q_dma_wr && dfull;
            can_wr_q  <= rx_queue_en && room_ok && !lfull;
            if (dwr) dwr_q <= dwr_q + 1'b1;
            if (dpop) drd_q <= drd_q + 1'b1;
            if (stored_q && !lfull) lwr_q <= lwr_q + 1'b1;
            if (lpop) lrd_q <= lrd_q + 1'b1;
            state_q    <= state_d;
            out_wr_q   <= out_wr_d;
            out_data_q <= out_data_d;
            out_ctrl_q <= out_ctrl_d;
            removed_q  <= removed_d;
        end
    end

    assign cpu_q_dma_can_wr_pkt = can_wr_q;
    assign out_wr               = out_wr_q;
    assign out_data             = out_data_q;
    assign out_ctrl             = out_ctrl_q;
    assign rx_pkt_stored        = stored_q;
    assign rx_pkt_removed       = removed_q;
    assign rx_q_overrun         = overrun_q;
    assign rx_pkt_byte_cnt      = stored_bytes_q;
    assign rx_pkt_word_cnt      = stored_words_q;
endmodule

// File: tb/tb_cpu_dma_rx_queue.sv
// Directed bench for cpu_dma_rx_queue: packet framing, throttling, overrun, enable gating, reset.
module tb_cpu_dma_rx_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic        can_wr;
    logic        dma_wr;
    logic [31:0] dma_data;
    logic [3:0]  dma_ctrl;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy;
    logic        rx_queue_en;
    logic        stored, removed, overrun;
    logic [11:0] byte_cnt;
    logic [9:0]  word_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [71:0] cap [1024];
    int cap_n = 0;
    int exp_rd = 0;
    int stored_n = 0, removed_n = 0, overrun_n = 0;
    bit thr = 1'b0;

    always #5 clk = ~clk;

    cpu_dma_rx_queue dut (
        .clk                  (clk),
        .reset                (reset),
        .cpu_q_dma_can_wr_pkt (can_wr),
        .cpu_q_dma_wr         (dma_wr),
        .cpu_q_dma_wr_data    (dma_data),
        .cpu_q_dma_wr_ctrl    (dma_ctrl),
        .out_data             (out_data),
        .out_ctrl             (out_ctrl),
        .out_wr               (out_wr),
        .out_rdy              (out_rdy),
        .rx_queue_en          (rx_queue_en),
        .rx_pkt_stored        (stored),
        .rx_pkt_removed       (removed),
        .rx_q_overrun         (overrun),
        .rx_pkt_byte_cnt      (byte_cnt),
        .rx_pkt_word_cnt      (word_cnt)
    );

    always @(negedge clk) begin
        if (out_wr && cap_n < 1024) begin
            cap[cap_n] = {out_ctrl, out_data};
            cap_n++;
        end
        if (stored) stored_n++;
        if (removed) removed_n++;
        if (overrun) overrun_n++;
    end

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: byte i of a packet is base+i; header then big-endian 64-bit words.
    function automatic logic [71:0] exp_word(int nbytes, logic [7:0] base, int j);
        logic [71:0] w;
        int words, k, idx;
        w = '0;
        words = (nbytes + 7) / 8;
        if (j == 0) begin
            w[71:64] = 8'hff;
            w[15:0]  = 16'(nbytes);
            w[47:32] = 16'(words);
        end else begin
            k = j - 1;
            for (int b = 0; b < 8; b++) begin
                idx = 8 * k + b;
                if (idx < nbytes) w[63-8*b -: 8] = base + 8'(idx);
            end
            if (8 * k + 8 >= nbytes) w[71:64] = 8'h80 >> ((nbytes - 1) % 8);
        end
        return w;
    endfunction

    task automatic send_pkt(input int nbytes, input logic [7:0] base, input bit term);
        int nw, idx;
        nw = term ? (nbytes + 3) / 4 : nbytes / 4;
        for (int w = 0; w < nw; w++) begin
            dma_wr   = 1'b1;
            dma_data = '0;
            for (int k = 0; k < 4; k++) begin
                idx = 4 * w + k;
                if (idx < nbytes) dma_data[8*k +: 8] = base + 8'(idx);
            end
            dma_ctrl = (term && w == nw - 1) ? 4'(1 << ((nbytes - 1) % 4)) : 4'd0;
            if (thr) out_rdy = ~out_rdy;
            @(posedge clk);
            #1;
        end
        dma_wr   = 1'b0;
        dma_ctrl = '0;
        if (term) begin
            check("stored_pulse", 72'(stored), 72'd1);
            check("stored_bytes", 72'(byte_cnt), 72'(nbytes));
            check("stored_words", 72'(word_cnt), 72'((nbytes + 7) / 8));
        end
    endtask

    task automatic wait_caps(input int target, input int budget);
        int c;
        c = 0;
        while (cap_n < target && c < budget) begin
            if (thr) out_rdy = ~out_rdy;
            @(posedge clk);
            #1;
            c++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("out_count", 72'(cap_n), 72'(target));
    endtask

    task automatic check_pkt(input string tag, input int nbytes, input logic [7:0] base);
        int words;
        words = (nbytes + 7) / 8;
        for (int j = 0; j <= words; j++)
            check($sformatf("%s_w%0d", tag, j), cap[exp_rd+j], exp_word(nbytes, base, j));
        exp_rd += words + 1;
    endtask

    initial begin
        int s0, r0, o0, c0;
        reset = 1'b1; rx_queue_en = 1'b1; out_rdy = 1'b1;
        dma_wr = 1'b0; dma_data = '0; dma_ctrl = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_can_wr", 72'(can_wr), 72'd0);
        check("rst_out_wr", 72'(out_wr), 72'd0);
        check("rst_stored", 72'(stored), 72'd0);
        check("rst_overrun", 72'(overrun), 72'd0);
        check("rst_byte_cnt", 72'(byte_cnt), 72'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("can_wr_after_rst", 72'(can_wr), 72'd1);

        // 64-byte packet: last DMA word full, last ctrl 8'h01.
        send_pkt(64, 8'h10, 1'b1);
        wait_caps(9, 200);
        check("p64_hdr", cap[0], 72'hff_0000_0008_0000_0040);
        check("p64_last", cap[8], 72'h01_4849_4a4b_4c4d_4e4f);
        check_pkt("p64", 64, 8'h10);

        // 57-byte packet: last DMA word in the low-address half, 1 byte.
        send_pkt(57, 8'h20, 1'b1);
        wait_caps(18, 200);
        check("p57_last", cap[17], 72'h80_5800_0000_0000_0000);
        check_pkt("p57", 57, 8'h20);

        // 61-byte packet: last DMA word in the high-address half, 1 byte.
        send_pkt(61, 8'h40, 1'b1);
        wait_caps(27, 200);
        check("p61_hdr", cap[18], 72'hff_0000_0008_0000_003d);
        check("p61_last", cap[26], 72'h08_7879_7a7b_7c00_0000);
        check_pkt("p61", 61, 8'h40);

        // 1514-byte packet with out_rdy toggling every cycle.
        thr = 1'b1;
        send_pkt(1514, 8'h33, 1'b1);
        wait_caps(27 + 191, 2000);
        thr = 1'b0;
        out_rdy = 1'b1;
        check_pkt("p1514", 1514, 8'h33);

        // Three back-to-back packets held by rx_queue_en = 0, then released.
        rx_queue_en = 1'b0;
        s0 = stored_n; r0 = removed_n; c0 = cap_n;
        send_pkt(16, 8'h80, 1'b1);
        send_pkt(24, 8'h90, 1'b1);
        send_pkt(8, 8'ha0, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        check("en0_no_out", 72'(cap_n), 72'(c0));
        check("en0_stored3", 72'(stored_n - s0), 72'd3);
        rx_queue_en = 1'b1;
        wait_caps(c0 + 9, 200);
        check_pkt("b2b_a", 16, 8'h80);
        check_pkt("b2b_b", 24, 8'h90);
        check_pkt("b2b_c", 8, 8'ha0);
        check("b2b_removed3", 72'(removed_n - r0), 72'd3);

        // Overrun: fill the data FIFO with body words, then write one more.
        out_rdy = 1'b0;
        o0 = overrun_n;
        check("ovr_can_wr_start", 72'(can_wr), 72'd1);
        send_pkt(4096, 8'h00, 1'b0);
        check("ovr_can_wr_full", 72'(can_wr), 72'd0);
        check("ovr_none_yet", 72'(overrun_n - o0), 72'd0);
        dma_wr = 1'b1; dma_data = 32'hdead_beef; dma_ctrl = 4'd0;
        @(posedge clk);
        #1;
        dma_wr = 1'b0;
        check("ovr_pulse", 72'(overrun), 72'd1);
        check("ovr_can_wr_pulse", 72'(can_wr), 72'd0);
        @(posedge clk);
        #1;
        check("ovr_pulse_end", 72'(overrun), 72'd0);
        check("ovr_pulse_count", 72'(overrun_n - o0), 72'd1);
        check("ovr_no_out", 72'(cap_n), 72'(exp_rd));

        // Reset flushes the full FIFO.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst2_out_wr", 72'(out_wr), 72'd0);
        check("rst2_can_wr", 72'(can_wr), 72'd0);
        reset = 1'b0;
        out_rdy = 1'b1;
        @(posedge clk);
        #1;
        check("rst2_flushed", 72'(can_wr), 72'd1);

        // Partial packet discarded by reset, then a clean 32-byte packet.
        send_pkt(24, 8'h55, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst3_out_wr", 72'(out_wr), 72'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        send_pkt(32, 8'hc0, 1'b1);
        wait_caps(exp_rd + 5, 200);
        check("p32_hdr", cap[exp_rd], 72'hff_0000_0004_0000_0020);
        check_pkt("p32", 32, 8'hc0);
        repeat (20) @(posedge clk);
        #1;
        check("p32_no_extra", 72'(cap_n), 72'(exp_rd));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
